// File: rtl/clk_div_pkg.sv
//------------------------------------------------------------------------------
// Module      : clk_div_pkg
// Description : Shared state encoding and default parameters for the clock
//               divider and its downstream monitor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package clk_div_pkg;

    localparam int unsigned DEF_DIV_PARAM = 10;
    localparam int unsigned DEF_CNT_W     = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT_RISE = 2'd0;
    localparam state_t ST_HIGH      = 2'd1;
    localparam state_t ST_LOW       = 2'd2;

endpackage

`default_nettype wire

// File: rtl/clk_edge_det.sv
//------------------------------------------------------------------------------
// Module      : clk_edge_det
// Description : Edge detector for a same-domain signal; gives the raw rise/fall
//               terms plus one-cycle registered pulses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clk_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_rise,
    output logic o_fall,
    output logic o_rise_pulse,
    output logic o_fall_pulse
);

    logic r_din_q;
    logic r_rise_pulse;
    logic r_fall_pulse;
    logic w_rise;
    logic w_fall;

    assign w_rise = i_din & ~r_din_q;
    assign w_fall = ~i_din & r_din_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_din_q      <= 1'b0;
            r_rise_pulse <= 1'b0;
            r_fall_pulse <= 1'b0;
        end else begin
            r_din_q      <= i_din;
            r_rise_pulse <= w_rise;
            r_fall_pulse <= w_fall;
        end
    end

    assign o_rise       = w_rise;
    assign o_fall       = w_fall;
    assign o_rise_pulse = r_rise_pulse;
    assign o_fall_pulse = r_fall_pulse;

endmodule

`default_nettype wire

// File: rtl/clk_div_monitor.sv
//------------------------------------------------------------------------------
// Module      : clk_div_monitor
// Description : Measures high/low phase lengths of a divided clock sampled in
//               the source domain; reports lock and a sticky error.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_PARAM = DEF_DIV_PARAM,
    parameter int unsigned LOCK_CNT  = 4,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div_in,
    input  logic             clr_err,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic             period_valid,
    output logic             locked,
    output logic             err
);

    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(DIV_PARAM / 2);
    localparam logic [CNT_W-1:0] C_DIV  = CNT_W'(DIV_PARAM);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [3:0]       C_LOCK = 4'(LOCK_CNT);

    logic             w_rise;
    logic             w_fall;

    state_t           r_state,      w_state_nxt;
    logic [CNT_W-1:0] r_ph_cnt,     w_ph_cnt_nxt;
    logic [CNT_W-1:0] r_high_i,     w_high_i_nxt;
    logic [CNT_W-1:0] r_high_cnt,   w_high_cnt_nxt;
    logic [CNT_W-1:0] r_low_cnt,    w_low_cnt_nxt;
    logic             r_period_vld, w_period_vld_nxt;
    logic [3:0]       r_good_cnt,   w_good_cnt_nxt;
    logic             r_locked,     w_locked_nxt;
    logic             r_err,        w_err_nxt;
    logic             w_err_evt;
    logic [3:0]       w_good_inc;

    clk_edge_det u_edge_det (
        .clk          (clk),
        .rst          (rst),
        .i_din        (clk_div_in),
        .o_rise       (w_rise),
        .o_fall       (w_fall),
        .o_rise_pulse (rise_pulse),
        .o_fall_pulse (fall_pulse)
    );

    assign w_good_inc = (r_good_cnt < C_LOCK) ? r_good_cnt + 4'd1 : r_good_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_WAIT_RISE;
            r_ph_cnt     <= '0;
            r_high_i     <= '0;
            r_high_cnt   <= '0;
            r_low_cnt    <= '0;
            r_period_vld <= 1'b0;
            r_good_cnt   <= 4'd0;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ph_cnt     <= w_ph_cnt_nxt;
            r_high_i     <= w_high_i_nxt;
            r_high_cnt   <= w_high_cnt_nxt;
            r_low_cnt    <= w_low_cnt_nxt;
            r_period_vld <= w_period_vld_nxt;
            r_good_cnt   <= w_good_cnt_nxt;
            r_locked     <= w_locked_nxt;
            r_err        <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ph_cnt_nxt     = r_ph_cnt;
        w_high_i_nxt     = r_high_i;
        w_high_cnt_nxt   = r_high_cnt;
        w_low_cnt_nxt    = r_low_cnt;
        w_period_vld_nxt = 1'b0;
        w_good_cnt_nxt   = r_good_cnt;
        w_locked_nxt     = r_locked;
        w_err_evt        = 1'b0;

        case (r_state)
            ST_WAIT_RISE: begin
                if (w_rise) begin
                    w_state_nxt  = ST_HIGH;
                    w_ph_cnt_nxt = C_ONE;
                end
            end
            ST_HIGH: begin
                if (w_fall) begin
                    w_high_i_nxt = r_ph_cnt;
                    w_ph_cnt_nxt = C_ONE;
                    w_state_nxt  = ST_LOW;
                end else if (r_ph_cnt >= C_DIV) begin
                    w_err_evt    = 1'b1;
                    w_ph_cnt_nxt = '0;
                    w_state_nxt  = ST_WAIT_RISE;
                end else begin
                    w_ph_cnt_nxt = r_ph_cnt + C_ONE;
                end
            end
            ST_LOW: begin
                if (w_rise) begin
                    w_high_cnt_nxt   = r_high_i;
                    w_low_cnt_nxt    = r_ph_cnt;
                    w_period_vld_nxt = 1'b1;
                    w_ph_cnt_nxt     = C_ONE;
                    w_state_nxt      = ST_HIGH;
                    if ((r_high_i == C_HALF) && (r_ph_cnt == C_HALF)) begin
                        w_good_cnt_nxt = w_good_inc;
                        w_locked_nxt   = (w_good_inc == C_LOCK);
                    end else begin
                        w_err_evt = 1'b1;
                    end
                end else if (r_ph_cnt >= C_DIV) begin
                    w_err_evt    = 1'b1;
                    w_ph_cnt_nxt = '0;
                    w_state_nxt  = ST_WAIT_RISE;
                end else begin
                    w_ph_cnt_nxt = r_ph_cnt + C_ONE;
                end
            end
            default: begin
                w_state_nxt  = ST_WAIT_RISE;
                w_ph_cnt_nxt = '0;
            end
        endcase

        if (w_err_evt) begin
            w_good_cnt_nxt = 4'd0;
            w_locked_nxt   = 1'b0;
        end
        // A new error event outranks a simultaneous clear request.
        w_err_nxt = w_err_evt | (r_err & ~clr_err);
    end

    assign high_cnt     = r_high_cnt;
    assign low_cnt      = r_low_cnt;
    assign period_valid = r_period_vld;
    assign locked       = r_locked;
    assign err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
//------------------------------------------------------------------------------
// Module      : tb_clk_div_monitor
// Description : Scoreboard bench for clk_div_monitor with directed sources.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clk_div_monitor;
    import clk_div_pkg::*;

    localparam int DIV  = 10;
    localparam int LOCK = 4;
    localparam int W    = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_div_in;
    logic         clr_err;
    logic         rise_pulse;
    logic         fall_pulse;
    logic [W-1:0] high_cnt;
    logic [W-1:0] low_cnt;
    logic         period_valid;
    logic         locked;
    logic         err;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] l;
        logic       e;
        logic       lk;
    } exp_t;

    exp_t q[$];
    exp_t m_exp;
    int   checks = 0;
    int   passed = 0;

    logic m_q, m_rise, m_fall;

    clk_div_monitor #(
        .DIV_PARAM (DIV),
        .LOCK_CNT  (LOCK),
        .CNT_W     (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_div_in   (clk_div_in),
        .clr_err      (clr_err),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .high_cnt     (high_cnt),
        .low_cnt      (low_cnt),
        .period_valid (period_valid),
        .locked       (locked),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Edge pulses are defined directly from the sampled input history.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q    <= 1'b0;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
        end else begin
            m_q    <= clk_div_in;
            m_rise <= clk_div_in & ~m_q;
            m_fall <= ~clk_div_in & m_q;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("rise_pulse", int'(rise_pulse), int'(m_rise));
            chk("fall_pulse", int'(fall_pulse), int'(m_fall));
            if (period_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_valid: got high=%0d low=%0d expected no period_valid", high_cnt, low_cnt);
                end else begin
                    m_exp = q.pop_front();
                    chk("high_cnt", int'(high_cnt), int'(m_exp.h));
                    chk("low_cnt",  int'(low_cnt),  int'(m_exp.l));
                    chk("err",      int'(err),      int'(m_exp.e));
                    chk("locked",   int'(locked),   int'(m_exp.lk));
                end
            end
        end
    end

    task automatic drv(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clk_div_in = v;
        end
    endtask

    // One source period; its measurement appears at the next period's rise.
    task automatic period(input int h, input int l, input logic e, input logic lk,
                          input int clr_at = -1, input logic clr_chk = 1'b0);
        q.push_back('{h: 8'(h), l: 8'(l), e: e, lk: lk});
        for (int i = 0; i < h + l; i++) begin
            @(negedge clk);
            if (clr_chk && i == clr_at + 1) chk("err_after_clr", int'(err), 0);
            clk_div_in = (i < h);
            clr_err    = (i == clr_at);
        end
        clr_err = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_high_cnt"}, int'(high_cnt), 0);
        chk({tag, "_low_cnt"}, int'(low_cnt), 0);
        chk({tag, "_period_valid"}, int'(period_valid), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_rise_pulse"}, int'(rise_pulse), 0);
        chk({tag, "_fall_pulse"}, int'(fall_pulse), 0);
        chk({tag, "_state"}, int'(dut.r_state), int'(ST_WAIT_RISE));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        clk_div_in = 1'b0;
        clr_err    = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        drv(1'b0, 3);

        // Correct source: lock on the 4th measured period.
        for (int k = 0; k < 6; k++) period(5, 5, 1'b0, k >= 3);

        // Glitch inside a high phase, then recovery to lock with sticky err.
        period(2, 1, 1'b1, 1'b0);
        period(2, 5, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) period(5, 5, 1'b1, k == 3);

        // clr_err alone during a low phase.
        period(5, 5, 1'b0, 1'b1, 7, 1'b1);

        // Wrong ratio, and clr_err on the same edge as the bad period.
        period(6, 6, 1'b1, 1'b0);
        period(6, 6, 1'b1, 1'b0);
        period(5, 5, 1'b1, 1'b0, 0, 1'b0);
        period(5, 5, 1'b0, 1'b0, 6, 1'b1);
        period(5, 5, 1'b0, 1'b0);
        period(5, 5, 1'b0, 1'b1);

        // Stuck high after lock.
        drv(1'b1, 8);
        chk("pre_stuck_err", int'(err), 0);
        chk("pre_stuck_locked", int'(locked), 1);
        drv(1'b1, 5);
        chk("stuck_err", int'(err), 1);
        chk("stuck_locked", int'(locked), 0);
        chk("stuck_state", int'(dut.r_state), int'(ST_WAIT_RISE));

        // Restore a good source: relock, err remains set.
        drv(1'b0, 4);
        for (int k = 0; k < 4; k++) period(5, 5, 1'b1, k == 3);

        // Reset during a low phase while locked.
        drv(1'b1, 5);
        drv(1'b0, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drv(1'b0, 3);
        chk("queue_after_reset", q.size(), 0);
        period(5, 5, 1'b0, 1'b0);
        chk("no_early_valid", q.size(), 1);
        drv(1'b1, 2);
        @(negedge clk);
        chk("first_valid_seen", q.size(), 0);
        drv(1'b1, 2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
